harris_response_stream: RTL and testbench
=========================================

HARRIS_RESPONSE_STREAM -- requirements
Module: harris_response_stream

Interface
REQ-001 SHALL have parameter P_W, 13, signed bit width of each Ix/Iy gradient sample.
REQ-002 SHALL have parameter P_WIN, 3, window side length; legal values are 3 and 5.
REQ-003 SHALL have parameter P_OUT_W, 18, signed bit width of the response output.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  column sample offered.
REQ-007 SHALL have port in_ready  output  1  block accepts a column this cycle.
REQ-008 SHALL have port in_sol  input  1  start-of-line; the offered column is the first column of a new line.
REQ-009 SHALL have port in_ix  input  P_WIN*P_W  signed Ix column; row 0 in the LSBs.
REQ-010 SHALL have port in_iy  input  P_WIN*P_W  signed Iy column; same packing as in_ix.
REQ-011 SHALL have port scale  input  8  trace right-shift amount, sampled at acceptance.
REQ-012 SHALL have port out_valid  output  1  response valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the response.
REQ-014 SHALL have port out  output  P_OUT_W  signed Harris response det/trace.

Function
REQ-015 SHALL accept a column on a rising edge where in_valid and in_ready are both 1; in_ready SHALL equal 1 only in state IDLE.
REQ-016 SHALL compute, per accepted column, the sums of Ix*Ix, Ix*Iy and Iy*Iy over its P_WIN rows; all products are full-width signed (2*P_W bits).
REQ-017 SHALL hold the last P_WIN column sums in a shift register, plus a column count that saturates at P_WIN.
REQ-018 SHALL, on an accepted column with in_sol=1, discard all stored columns, store the new column as the only one, and set the count to 1.
REQ-019 SHALL, when an accepted column makes the count equal P_WIN (full window), move IDLE->SUM; otherwise it SHALL stay in IDLE.
REQ-020 SHALL, in SUM, register A, B and C; each is the sum of its term over the P_WIN stored columns, with accumulator width ACC_W = 2*P_W+5, and the state SHALL then move to PROD.
REQ-021 SHALL, in PROD, register det = A*C - B*B at width 2*ACC_W and trace = (A+C) >>> scale_sampled; a shift of ACC_W or more SHALL yield 0; the state SHALL then move to DIV.
REQ-022 SHALL, in DIV, run a sequential restoring divide of |det| by trace that produces one quotient bit per cycle for exactly 2*ACC_W cycles, then move to DONE.
REQ-023 SHALL make the result sign that of det, truncated toward zero.
REQ-024 SHALL saturate the result to [-(2^(P_OUT_W-1)), 2^(P_OUT_W-1)-1].
REQ-025 SHALL skip the divide when trace==0 and go from PROD directly to DONE with result 0.
REQ-026 SHALL assert out_valid only in DONE and hold out stable while out_valid=1 and out_ready=0.
REQ-027 SHALL, in DONE, move to IDLE on the cycle out_ready=1.
REQ-028 SHALL keep in_ready=1 in the first IDLE cycle, so a back-to-back column can be accepted in that cycle.
REQ-029 SHALL set the latency from an accepting edge to out_valid to 3+2*ACC_W cycles when trace!=0 and 3 cycles when trace==0.
REQ-030 SHALL keep the stored window intact across SUM/PROD/DIV/DONE; with count at P_WIN, every later column (in_sol=0) SHALL trigger a new response (sliding window).
REQ-031 SHALL keep out equal to its last value while out_valid=0, and 0 after reset.

Reset
REQ-032 SHALL, while reset=1 at any time (including mid-DIV), immediately force state IDLE, count 0, column registers 0, A/B/C/det/trace/quotient 0, out 0, out_valid 0 and in_ready 0.
REQ-033 SHALL drive in_ready=1 on the first clk edge after reset deasserts; a divide in flight at reset SHALL never produce out_valid.

Verification
REQ-034 SHALL cover scaling and divide: P_W=13, P_WIN=3; col0 Ix=(3,0,0), Iy=0, in_sol=1; col1 Ix=0, Iy=(4,0,0); col2 all 0; scale=0 -> A=9, C=16, B=0, det=144, trace=25, out=5 after 3+62 cycles. Same columns with scale=2 -> trace=6, out=24.
REQ-035 SHALL cover zero trace: three all-zero columns -> out_valid 3 cycles after the third accept, out=0.
REQ-036 SHALL cover saturation: col0 Ix=(4095,0,0), col1 Iy=(4095,0,0), col2 zero, scale=20 -> trace=31, quotient ~9.07e12 -> out=131071.
REQ-037 SHALL cover sliding window and in_sol: after REQ-034, push col3 all zero -> out=0 (window cols1..3: A=0). Then push two columns with in_sol=1 on the first -> no out_valid until the third column of the new line.
REQ-038 SHALL cover backpressure and reset: hold out_ready=0 for 10 cycles in DONE -> out stable and in_ready=0. Assert reset mid-DIV -> out_valid=0, out=0, and the next full window produces a correct result.

Source files
------------

// File: rtl/harris_response_stream.sv
// Harris corner response for a streamed gradient window.
// Columns of Ix/Iy arrive one per handshake; once P_WIN columns of the current
// line are stored, the window sums A/B/C are formed and the response det/trace
// is computed with a bit-serial restoring divider, then saturated to P_OUT_W.
module harris_response_stream #(
    parameter int P_W     = 13,
    parameter int P_WIN   = 3,
    parameter int P_OUT_W = 18
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sol,
    input  logic [P_WIN*P_W-1:0]       in_ix,
    input  logic [P_WIN*P_W-1:0]       in_iy,
    input  logic [7:0]                 scale,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [P_OUT_W-1:0]  out
);

    localparam int ACC_W  = 2*P_W + 5;
    localparam int DET_W  = 2*ACC_W;
    localparam int TR_W   = ACC_W + 1;
    localparam int DCNT_W = $clog2(DET_W);
    localparam logic [DET_W-1:0] POS_LIM = DET_W'((64'd1 << (P_OUT_W-1)) - 64'd1);
    localparam logic [DET_W-1:0] NEG_LIM = DET_W'(64'd1 << (P_OUT_W-1));

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SUM  = 3'd1,
        PROD = 3'd2,
        DIV  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Apply the sign of det to the quotient magnitude and clamp to the output range.
    function automatic logic signed [P_OUT_W-1:0] sat_result(
        input logic [DET_W-1:0] mag,
        input logic             neg
    );
        logic [DET_W-1:0] neg_mag;
        neg_mag = ~mag + DET_W'(1);
        if (neg) begin
            if (mag > NEG_LIM) sat_result = {1'b1, {(P_OUT_W-1){1'b0}}};
            else               sat_result = neg_mag[P_OUT_W-1:0];
        end else begin
            if (mag > POS_LIM) sat_result = {1'b0, {(P_OUT_W-1){1'b1}}};
            else               sat_result = mag[P_OUT_W-1:0];
        end
    endfunction

    state_t                    state_r;
    logic                      in_ready_r;
    logic                      out_valid_r;
    logic signed [P_OUT_W-1:0] out_r;

    logic signed [ACC_W-1:0]   col_xx_r [P_WIN];
    logic signed [ACC_W-1:0]   col_xy_r [P_WIN];
    logic signed [ACC_W-1:0]   col_yy_r [P_WIN];
    logic [2:0]                count_r;
    logic [7:0]                scale_r;

    logic signed [ACC_W-1:0]   sum_a_r, sum_b_r, sum_c_r;
    logic signed [DET_W-1:0]   det_r;
    logic signed [TR_W-1:0]    trace_r;
    logic                      prod_ph_r;
    logic [DET_W-1:0]          dvd_r;
    logic [TR_W-1:0]           rem_r;
    logic [DET_W-2:0]          quo_r;
    logic [DCNT_W-1:0]         dcnt_r;

    logic                      accept_s;
    logic [2:0]                count_next_s;
    logic signed [2*P_W-1:0]   ix_w_s, iy_w_s, p_xx_s, p_xy_s, p_yy_s;
    logic signed [ACC_W-1:0]   new_xx_s, new_xy_s, new_yy_s;
    logic signed [ACC_W-1:0]   sum_a_s, sum_b_s, sum_c_s;
    logic signed [DET_W-1:0]   a_ext_s, b_ext_s, c_ext_s, det_s;
    logic signed [TR_W-1:0]    ac_s, trace_s;
    logic [DET_W-1:0]          det_mag_s;
    logic [TR_W:0]             rem_shift_s;
    logic [TR_W-1:0]           rem_diff_s, rem_next_s;
    logic                      q_bit_s;
    logic [DET_W-1:0]          quo_next_s;
    logic signed [P_OUT_W-1:0] result_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out       = out_r;
    assign accept_s  = in_valid & in_ready_r;

    // Column count after an accept: restart on a new line, otherwise saturate at P_WIN.
    always_comb begin
        count_next_s = count_r;
        if (in_sol) begin
            count_next_s = 3'd1;
        end else if (count_r == 3'(P_WIN)) begin
            count_next_s = 3'(P_WIN);
        end else begin
            count_next_s = count_r + 3'd1;
        end
    end

    // Per-column gradient products summed over the rows of the offered column.
    always_comb begin
        new_xx_s = '0;
        new_xy_s = '0;
        new_yy_s = '0;
        ix_w_s   = '0;
        iy_w_s   = '0;
        p_xx_s   = '0;
        p_xy_s   = '0;
        p_yy_s   = '0;
        for (int r = 0; r < P_WIN; r++) begin
            ix_w_s   = {{P_W{in_ix[r*P_W+P_W-1]}}, in_ix[r*P_W +: P_W]};
            iy_w_s   = {{P_W{in_iy[r*P_W+P_W-1]}}, in_iy[r*P_W +: P_W]};
            p_xx_s   = ix_w_s * ix_w_s;
            p_xy_s   = ix_w_s * iy_w_s;
            p_yy_s   = iy_w_s * iy_w_s;
            new_xx_s = new_xx_s + {{(ACC_W-2*P_W){p_xx_s[2*P_W-1]}}, p_xx_s};
            new_xy_s = new_xy_s + {{(ACC_W-2*P_W){p_xy_s[2*P_W-1]}}, p_xy_s};
            new_yy_s = new_yy_s + {{(ACC_W-2*P_W){p_yy_s[2*P_W-1]}}, p_yy_s};
        end
    end

    // Window sums over the stored columns.
    always_comb begin
        sum_a_s = '0;
        sum_b_s = '0;
        sum_c_s = '0;
        for (int c = 0; c < P_WIN; c++) begin
            sum_a_s = sum_a_s + col_xx_r[c];
            sum_b_s = sum_b_s + col_xy_r[c];
            sum_c_s = sum_c_s + col_yy_r[c];
        end
    end

    // Determinant and scaled trace of the registered structure tensor.
    always_comb begin
        a_ext_s = {{(DET_W-ACC_W){sum_a_r[ACC_W-1]}}, sum_a_r};
        b_ext_s = {{(DET_W-ACC_W){sum_b_r[ACC_W-1]}}, sum_b_r};
        c_ext_s = {{(DET_W-ACC_W){sum_c_r[ACC_W-1]}}, sum_c_r};
        det_s   = a_ext_s * c_ext_s - b_ext_s * b_ext_s;
        ac_s    = {sum_a_r[ACC_W-1], sum_a_r} + {sum_c_r[ACC_W-1], sum_c_r};
        if (scale_r >= 8'(ACC_W)) begin
            trace_s = '0;
        end else begin
            trace_s = ac_s >>> scale_r;
        end
    end

    // One restoring-divide step; the remainder always stays below trace, so the
    // low TR_W bits of the subtraction are exact.
    always_comb begin
        det_mag_s   = det_r[DET_W-1] ? (~det_r + DET_W'(1)) : det_r;
        rem_shift_s = {rem_r, dvd_r[DET_W-1]};
        rem_diff_s  = rem_shift_s[TR_W-1:0] - $unsigned(trace_r);
        if (rem_shift_s >= {1'b0, $unsigned(trace_r)}) begin
            q_bit_s    = 1'b1;
            rem_next_s = rem_diff_s;
        end else begin
            q_bit_s    = 1'b0;
            rem_next_s = rem_shift_s[TR_W-1:0];
        end
        quo_next_s = {quo_r, q_bit_s};
        result_s   = sat_result(quo_next_s, det_r[DET_W-1]);
    end

    // Column shift register, line-start handling, column count and scale capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < P_WIN; c++) begin
                col_xx_r[c] <= '0;
                col_xy_r[c] <= '0;
                col_yy_r[c] <= '0;
            end
            count_r <= 3'd0;
            scale_r <= 8'd0;
        end else if (accept_s) begin
            scale_r <= scale;
            count_r <= count_next_s;
            col_xx_r[0] <= new_xx_s;
            col_xy_r[0] <= new_xy_s;
            col_yy_r[0] <= new_yy_s;
            for (int c = 1; c < P_WIN; c++) begin
                col_xx_r[c] <= in_sol ? '0 : col_xx_r[c-1];
                col_xy_r[c] <= in_sol ? '0 : col_xy_r[c-1];
                col_yy_r[c] <= in_sol ? '0 : col_yy_r[c-1];
            end
        end
    end

    // Response FSM: sum, products (two cycles: capture then dispatch), divide, hand-off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_r       <= '0;
            sum_a_r     <= '0;
            sum_b_r     <= '0;
            sum_c_r     <= '0;
            det_r       <= '0;
            trace_r     <= '0;
            prod_ph_r   <= 1'b0;
            dvd_r       <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            dcnt_r      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && (count_next_s == 3'(P_WIN))) begin
                        state_r    <= SUM;
                        in_ready_r <= 1'b0;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                SUM: begin
                    sum_a_r <= sum_a_s;
                    sum_b_r <= sum_b_s;
                    sum_c_r <= sum_c_s;
                    state_r <= PROD;
                end
                PROD: begin
                    if (!prod_ph_r) begin
                        det_r     <= det_s;
                        trace_r   <= trace_s;
                        prod_ph_r <= 1'b1;
                    end else begin
                        prod_ph_r <= 1'b0;
                        if (trace_r == '0) begin
                            out_r       <= '0;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            dvd_r   <= det_mag_s;
                            rem_r   <= '0;
                            quo_r   <= '0;
                            dcnt_r  <= '0;
                            state_r <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem_r <= rem_next_s;
                    dvd_r <= {dvd_r[DET_W-2:0], 1'b0};
                    quo_r <= quo_next_s[DET_W-2:0];
                    if (dcnt_r == DCNT_W'(DET_W-1)) begin
                        out_r       <= result_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        dcnt_r <= dcnt_r + DCNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_harris_response_stream.sv
// Bench for harris_response_stream: directed table, corner sequences and
// randomized windows checked against an arithmetic model of the response.
module tb_harris_response_stream;

    localparam int P_W     = 13;
    localparam int P_WIN   = 3;
    localparam int P_OUT_W = 18;
    localparam int ACC_W   = 2*P_W + 5;
    localparam int LAT_DIV = 3 + 2*ACC_W;
    localparam int LAT_Z   = 3;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_sol;
    logic [P_WIN*P_W-1:0]      in_ix;
    logic [P_WIN*P_W-1:0]      in_iy;
    logic [7:0]                scale;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [P_OUT_W-1:0] out;

    harris_response_stream #(.P_W(P_W), .P_WIN(P_WIN), .P_OUT_W(P_OUT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sol(in_sol), .in_ix(in_ix), .in_iy(in_iy), .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;

    // reference window: newest column at index 0
    longint mxx [3];
    longint mxy [3];
    longint myy [3];
    int     mcnt;
    bit     exp_full;
    longint exp_out;
    int     exp_lat;

    typedef struct {
        int     ix [9];
        int     iy [9];
        int     sc;
        longint eout;
        int     elat;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mcnt = 0;
        for (int c = 0; c < 3; c++) begin
            mxx[c] = 0; mxy[c] = 0; myy[c] = 0;
        end
        exp_full = 1'b0;
    endtask

    task automatic model_push(input int ix[3], input int iy[3], input bit sol, input int sc);
        longint xx, xy, yy, a, b, c, det, tr, q;
        xx = 0; xy = 0; yy = 0;
        for (int r = 0; r < 3; r++) begin
            xx += longint'(ix[r]) * longint'(ix[r]);
            xy += longint'(ix[r]) * longint'(iy[r]);
            yy += longint'(iy[r]) * longint'(iy[r]);
        end
        if (sol) begin
            for (int k = 0; k < 3; k++) begin
                mxx[k] = 0; mxy[k] = 0; myy[k] = 0;
            end
            mcnt = 1;
        end else begin
            for (int k = 2; k > 0; k--) begin
                mxx[k] = mxx[k-1]; mxy[k] = mxy[k-1]; myy[k] = myy[k-1];
            end
            if (mcnt < 3) mcnt++;
        end
        mxx[0] = xx; mxy[0] = xy; myy[0] = yy;
        exp_full = (mcnt == 3);
        a = mxx[0] + mxx[1] + mxx[2];
        b = mxy[0] + mxy[1] + mxy[2];
        c = myy[0] + myy[1] + myy[2];
        det = a*c - b*b;
        tr  = (sc >= ACC_W) ? 0 : ((a + c) >>> sc);
        if (tr == 0) begin
            q = 0;
            exp_lat = LAT_Z;
        end else begin
            q = det / tr;
            exp_lat = LAT_DIV;
        end
        if (q > 131071)  q = 131071;
        if (q < -131072) q = -131072;
        exp_out = q;
    endtask

    task automatic drive_col(input int ix[3], input int iy[3], input bit sol, input int sc);
        int waited;
        waited = 0;
        @(negedge clk);
        for (int r = 0; r < 3; r++) begin
            in_ix[r*P_W +: P_W] = ix[r][P_W-1:0];
            in_iy[r*P_W +: P_W] = iy[r][P_W-1:0];
        end
        in_sol   = sol;
        scale    = 8'(sc);
        in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("in_ready_for_accept", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sol   = 1'b0;
        model_push(ix, iy, sol, sc);
    endtask

    task automatic wait_out(input string name, input longint eo, input int el);
        int lat;
        lat = 0;
        while (lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        chk({name, "_latency"}, lat, el);
        chk({name, "_out"}, longint'(out), eo);
    endtask

    task automatic no_output(input string name, input int n);
        int seen;
        seen = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk(name, seen, 0);
    endtask

    task automatic run_window(input int v);
        int cix [3];
        int ciy [3];
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
                cix[r] = tbl[v].ix[c*3+r];
                ciy[r] = tbl[v].iy[c*3+r];
            end
            drive_col(cix, ciy, (c == 0), tbl[v].sc);
        end
    endtask

    function automatic int rand_grad(input int mag);
        int v;
        v = int'($urandom_range(0, 2*mag - 1)) - mag;
        if (v > 4095) v = 4095;
        return v;
    endfunction

    initial begin
        int zc [3];
        int cix [3];
        int ciy [3];
        int bad;
        int mag;
        logic signed [P_OUT_W-1:0] held;

        zc = '{0, 0, 0};
        tbl[0].ix = '{3,0,0, 0,0,0, 0,0,0};
        tbl[0].iy = '{0,0,0, 4,0,0, 0,0,0};
        tbl[0].sc = 0;  tbl[0].eout = 5;      tbl[0].elat = LAT_DIV;
        tbl[1].ix = '{3,0,0, 0,0,0, 0,0,0};
        tbl[1].iy = '{0,0,0, 4,0,0, 0,0,0};
        tbl[1].sc = 2;  tbl[1].eout = 24;     tbl[1].elat = LAT_DIV;
        tbl[2].ix = '{0,0,0, 0,0,0, 0,0,0};
        tbl[2].iy = '{0,0,0, 0,0,0, 0,0,0};
        tbl[2].sc = 0;  tbl[2].eout = 0;      tbl[2].elat = LAT_Z;
        tbl[3].ix = '{4095,0,0, 0,0,0, 0,0,0};
        tbl[3].iy = '{0,0,0, 4095,0,0, 0,0,0};
        tbl[3].sc = 20; tbl[3].eout = 131071; tbl[3].elat = LAT_DIV;

        reset = 1'b1; in_valid = 1'b0; in_sol = 1'b0;
        in_ix = '0; in_iy = '0; scale = 8'd0; out_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_out", longint'(out), 0);
        chk("reset_in_ready", longint'(in_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", longint'(in_ready), 1);

        // directed table
        for (int v = 0; v < 4; v++) begin
            run_window(v);
            wait_out($sformatf("table%0d", v), tbl[v].eout, tbl[v].elat);
        end

        // sliding window: cols 1..3 give A=0
        run_window(0);
        wait_out("slide_base", 5, LAT_DIV);
        drive_col(zc, zc, 1'b0, 0);
        wait_out("slide_zero_col", 0, LAT_DIV);

        // new line: nothing until the third column
        cix = '{3, 0, 0};
        drive_col(cix, zc, 1'b1, 0);
        no_output("sol_partial1", 8);
        chk("sol_partial1_ready", longint'(in_ready), 1);
        ciy = '{4, 0, 0};
        drive_col(zc, ciy, 1'b0, 0);
        no_output("sol_partial2", 8);
        drive_col(zc, zc, 1'b0, 0);
        wait_out("sol_full", 5, LAT_DIV);

        // backpressure in DONE
        cix = '{3, 0, 0};
        drive_col(cix, zc, 1'b1, 2);
        out_ready = 1'b0;
        drive_col(zc, ciy, 1'b0, 2);
        drive_col(zc, zc, 1'b0, 2);
        wait_out("bp_first", 24, LAT_DIV);
        held = out;
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        chk("bp_hold_cycles_bad", bad, 0);
        chk("bp_held_value", longint'(out), 24);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", longint'(out_valid), 0);
        chk("bp_release_ready", longint'(in_ready), 1);
        chk("out_kept_after_handoff", longint'(out), 24);

        // reset in the middle of a divide
        run_window(0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("middiv_reset_valid", longint'(out_valid), 0);
        chk("middiv_reset_out", longint'(out), 0);
        chk("middiv_reset_ready", longint'(in_ready), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("middiv_ready_after", longint'(in_ready), 1);
        no_output("middiv_no_stale", 80);
        run_window(3);
        wait_out("post_reset", 131071, LAT_DIV);

        // randomized windows against the reference model
        for (int it = 0; it < 40; it++) begin
            if (mcnt < 3 || $urandom_range(0, 2) == 0) begin
                for (int c = 0; c < 3; c++) begin
                    mag = 1 << $urandom_range(1, 12);
                    for (int r = 0; r < 3; r++) begin
                        cix[r] = rand_grad(mag);
                        ciy[r] = rand_grad(mag);
                    end
                    drive_col(cix, ciy, (c == 0), int'($urandom_range(0, 34)));
                end
            end else begin
                mag = 1 << $urandom_range(1, 12);
                for (int r = 0; r < 3; r++) begin
                    cix[r] = rand_grad(mag);
                    ciy[r] = rand_grad(mag);
                end
                drive_col(cix, ciy, 1'b0, int'($urandom_range(0, 34)));
            end
            chk("rand_window_full", longint'(exp_full), 1);
            wait_out($sformatf("rand%0d", it), exp_out, exp_lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
